// File: rtl/spi_flash_responder_pkg.sv
// Shared command codes, FSM state encoding and the JEDEC ID byte selector
// for the SPI flash responder.
package spi_flash_responder_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9f;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    ID     = 3'd4,
    IGNORE = 3'd5
  } state_e;

  // RDID streams the ID MSB byte first; idx cycles 0,1,2.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = id[23:16];
      2'd1:    id_byte = id[15:8];
      default: id_byte = id[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronisers for the asynchronous SPI pins plus registered
// edge pulses; MOSI is delayed to line up with the SCK rise pulse.
module spi_pin_sync (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_sck,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs_rise,
  output logic o_cs_fall,
  output logic o_cs_n,
  output logic o_mosi
);

  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;
  logic       sck_rise_q, sck_fall_q, cs_rise_q, cs_fall_q, cs_n_q, mosi_out_q;

  // CS_n resets low so that a frame already in progress cannot arm the FSM.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sck_q      <= '0;
      cs_q       <= '0;
      mosi_q     <= '0;
      sck_rise_q <= 1'b0;
      sck_fall_q <= 1'b0;
      cs_rise_q  <= 1'b0;
      cs_fall_q  <= 1'b0;
      cs_n_q     <= 1'b0;
      mosi_out_q <= 1'b0;
    end else begin
      sck_q      <= {sck_q[1:0], i_sck};
      cs_q       <= {cs_q[1:0], i_cs_n};
      mosi_q     <= {mosi_q[0], i_mosi};
      sck_rise_q <= sck_q[1] & ~sck_q[2];
      sck_fall_q <= ~sck_q[1] & sck_q[2];
      cs_rise_q  <= cs_q[1] & ~cs_q[2];
      cs_fall_q  <= ~cs_q[1] & cs_q[2];
      cs_n_q     <= cs_q[1];
      mosi_out_q <= mosi_q[1];
    end
  end

  assign o_sck_rise = sck_rise_q;
  assign o_sck_fall = sck_fall_q;
  assign o_cs_rise  = cs_rise_q;
  assign o_cs_fall  = cs_fall_q;
  assign o_cs_n     = cs_n_q;
  assign o_mosi     = mosi_out_q;

endmodule

// File: rtl/spi_flash_responder.sv
// Flash-side SPI responder: decodes READ/RDID from oversampled pins and
// serves bytes MSB-first, fetching READ data through a one-deep req/ack port.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int unsigned AW       = 24,
  parameter logic [23:0] JEDEC_ID = 24'hef4018
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_sck,
  input  logic          i_cs_n,
  input  logic          i_mosi,
  output logic          o_miso,
  output logic          o_miso_oe,
  output logic          o_rd_stb,
  output logic [AW-1:0] o_rd_addr,
  input  logic          i_rd_ack,
  input  logic [7:0]    i_rd_data,
  output logic          o_underrun
);

  localparam int unsigned    NB        = AW / 8;
  localparam int unsigned    BCW       = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);

  logic sck_rise, sck_fall, cs_rise, cs_fall, cs_n_s, mosi_s;

  spi_pin_sync u_sync (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_sck      (i_sck),
    .i_cs_n     (i_cs_n),
    .i_mosi     (i_mosi),
    .o_sck_rise (sck_rise),
    .o_sck_fall (sck_fall),
    .o_cs_rise  (cs_rise),
    .o_cs_fall  (cs_fall),
    .o_cs_n     (cs_n_s),
    .o_mosi     (mosi_s)
  );

  state_e         state_q;
  logic           armed_q;
  logic [2:0]     bit_cnt_q;
  logic [BCW-1:0] byte_cnt_q;
  logic [6:0]     rx_q;
  logic [AW-1:0]  addr_q;
  logic [7:0]     tx_q;
  logic [1:0]     id_idx_q;
  logic           miso_q, oe_q, rd_stb_q, underrun_q;
  logic [AW-1:0]  rd_addr_q;
  logic [7:0]     data_q;
  logic           pend_q, pend_d, have_q, have_d;
  logic [1:0]     drop_q, drop_d;

  logic          ack_drop, ack_take, last_addr_bit, load_evt, issue, abandon;
  logic [7:0]    cmd_byte, id_cur, load_byte;
  logic [AW-1:0] addr_full;

  assign cmd_byte      = {rx_q, mosi_s};
  assign addr_full     = {addr_q[AW-2:0], mosi_s};
  assign id_cur        = id_byte(JEDEC_ID, id_idx_q);
  assign load_byte     = (state_q == ID) ? id_cur : (have_q ? data_q : 8'hff);
  assign last_addr_bit = !cs_rise && sck_rise && (state_q == ADDR) &&
                         (bit_cnt_q == 3'd7) && (byte_cnt_q == LAST_BYTE);
  assign load_evt      = !cs_rise && sck_fall && (state_q == DATA) && (bit_cnt_q == 3'd0);
  assign issue         = last_addr_bit | load_evt;

  // The memory answers every strobe once, in order. A request abandoned by an
  // underrun or by CS_n rising still owes an ack; drop_q counts those so the
  // stale ack is swallowed instead of being taken as the next byte.
  assign ack_drop = i_rd_ack && (drop_q != 2'd0);
  assign ack_take = i_rd_ack && !ack_drop && pend_q;
  assign abandon  = (cs_rise | load_evt) & pend_q & ~ack_take;

  always_comb begin
    drop_d = drop_q;
    if (ack_drop && !abandon) begin
      drop_d = drop_q - 2'd1;
    end else if (abandon && !ack_drop && (drop_q != 2'd3)) begin
      drop_d = drop_q + 2'd1;
    end
    pend_d = pend_q;
    have_d = have_q;
    if (ack_take) begin
      pend_d = 1'b0;
      have_d = 1'b1;
    end
    if (cs_rise || load_evt) begin
      pend_d = 1'b0;
      have_d = 1'b0;
    end
    if (issue) begin
      pend_d = 1'b1;
      have_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= '0;
      rx_q       <= '0;
      addr_q     <= '0;
      tx_q       <= '0;
      id_idx_q   <= 2'd0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      rd_stb_q   <= 1'b0;
      rd_addr_q  <= '0;
      underrun_q <= 1'b0;
      data_q     <= '0;
      pend_q     <= 1'b0;
      have_q     <= 1'b0;
      drop_q     <= 2'd0;
    end else begin
      pend_q   <= pend_d;
      have_q   <= have_d;
      drop_q   <= drop_d;
      rd_stb_q <= 1'b0;
      if (ack_take) data_q <= i_rd_data;
      if (cs_n_s) armed_q <= 1'b1;

      // CS_n rising beats any SCK edge seen in the same cycle.
      if (cs_rise) begin
        state_q   <= IDLE;
        bit_cnt_q <= 3'd0;
        oe_q      <= 1'b0;
        miso_q    <= 1'b0;
      end else begin
        if (cs_fall && armed_q && (state_q == IDLE)) begin
          state_q   <= CMD;
          bit_cnt_q <= 3'd0;
        end

        if (sck_rise && (state_q != IDLE)) begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          case (state_q)
            CMD: begin
              rx_q <= cmd_byte[6:0];
              if (bit_cnt_q == 3'd7) begin
                byte_cnt_q <= '0;
                id_idx_q   <= 2'd0;
                if (cmd_byte == CMD_READ)      state_q <= ADDR;
                else if (cmd_byte == CMD_RDID) state_q <= ID;
                else                           state_q <= IGNORE;
              end
            end
            ADDR: begin
              addr_q <= addr_full;
              if (bit_cnt_q == 3'd7) begin
                if (byte_cnt_q == LAST_BYTE) begin
                  state_q   <= DATA;
                  rd_stb_q  <= 1'b1;
                  rd_addr_q <= addr_full;
                end else begin
                  byte_cnt_q <= byte_cnt_q + BCW'(1);
                end
              end
            end
            default: ;
          endcase
        end

        // Mode 0: MISO changes on the fall, a new byte loads when bit_cnt is 0.
        if (sck_fall && ((state_q == DATA) || (state_q == ID))) begin
          if (bit_cnt_q == 3'd0) begin
            oe_q   <= 1'b1;
            miso_q <= load_byte[7];
            tx_q   <= {load_byte[6:0], 1'b0};
            if (state_q == DATA) begin
              if (!have_q) underrun_q <= 1'b1;
              addr_q    <= addr_q + AW'(1);
              rd_stb_q  <= 1'b1;
              rd_addr_q <= addr_q + AW'(1);
            end else begin
              id_idx_q <= (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
            end
          end else begin
            miso_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign o_miso     = miso_q;
  assign o_miso_oe  = oe_q;
  assign o_rd_stb   = rd_stb_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_underrun = underrun_q;

endmodule
